// File: rtl/des_pkg.sv
// Shared DES sequencing constants: controller state encoding, round count and the
// per-round key rotate table that the datapath key schedule also uses.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Left-rotate amounts for C/D, indexed by encrypt round number 1..16 (total 28).
  localparam logic [1:0] SHIFT_TBL [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Out-of-range round numbers map to 0 so callers never index outside the table.
  function automatic logic [1:0] shift_lookup(input int r);
    logic [1:0] amt;
    amt = 2'd0;
    for (int i = 1; i <= DES_ROUNDS; i++) begin
      if (r == i) amt = SHIFT_TBL[i];
    end
    return amt;
  endfunction

endpackage

// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES datapath: accepts one block, drives load, 16 rounds
// with key-rotate control and the final permutation, then holds the result for the consumer.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_decrypt,
  output logic          in_ready,
  output logic          load_en,
  output logic          round_en,
  output logic [1:0]    shift_amt,
  output logic          shift_dir,
  output logic [RW-1:0] round_idx,
  output logic          final_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  state_t        state;
  state_t        state_next;
  logic [RW-1:0] round_cnt;
  logic          decrypt_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The counter already reads 1 in the first ROUND cycle and clears as the FSM leaves ROUND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_cnt    <= '0;
      decrypt_mode <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) decrypt_mode <= in_decrypt;

      if (state == LOAD)
        round_cnt <= RW'(1);
      else if (state == ROUND && round_cnt != RW'(ROUNDS))
        round_cnt <= round_cnt + RW'(1);
      else
        round_cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    state_next = ROUND;
      ROUND:   if (round_cnt == RW'(ROUNDS)) state_next = FINAL;
      FINAL:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are pure decodes of state and counter, so no input reaches them combinationally.
  // Decrypt walks the schedule backwards: no rotate in round 1, then right-rotates by
  // the encrypt amount for round ROUNDS+2-r.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    load_en   = (state == LOAD);
    round_en  = (state == ROUND);
    final_en  = (state == FINAL);
    out_valid = (state == HOLD);
    round_idx = '0;
    shift_amt = 2'd0;
    shift_dir = 1'b0;
    if (state == ROUND) begin
      round_idx = round_cnt;
      shift_dir = decrypt_mode;
      if (!decrypt_mode)
        shift_amt = shift_lookup(int'(round_cnt));
      else if (round_cnt == RW'(1))
        shift_amt = 2'd0;
      else
        shift_amt = shift_lookup(ROUNDS + 2 - int'(round_cnt));
    end
  end

endmodule
